serial_transmitter: RTL and testbench



---
 rtl/serial_transmitter_pkg.sv | 9 +
 rtl/serial_transmitter_piso_shift_reg.sv | 30 +++
 rtl/serial_transmitter.sv | 67 ++++++
 tb/tb_serial_transmitter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_transmitter_pkg.sv
// Shared definitions for the serial transmitter: FSM encodings and default word width.
package serial_transmitter_pkg;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/serial_transmitter_piso_shift_reg.sv
// Parallel-in/serial-out shift register, MSB first; load wins over shift.
module piso_shift_reg
    import serial_transmitter_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] pi,
    output logic              so
);

    logic [DATA_W-1:0] sr;

    // Zeros fill from the bottom, so the register is empty once a word has drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= pi;
        end else if (shift_en) begin
            sr <= {sr[DATA_W-2:0], 1'b0};
        end
    end

    assign so = sr[DATA_W-1];

endmodule

// File: rtl/serial_transmitter.sv
// Ready/valid word in, MSB-first serial out with a frame enable and end-of-word done pulse.
//   state  | meaning
//   IDLE   | line quiet, ready for a word
//   SEND   | shifting a word; ready again on its last bit for back-to-back frames
module serial_transmitter
    import serial_transmitter_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pi,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serOut,
    output logic              serOutEn,
    output logic              busy,
    output logic              done
);

    localparam int              CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             accept;
    logic             so;

    assign last_bit = (state == S_SEND) && (cnt == LAST);
    assign in_ready = (state == S_IDLE) || last_bit;
    assign accept   = in_valid && in_ready;

    // The counter simply holds in IDLE; it only returns to zero on a reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state <= S_SEND;
            cnt   <= '0;
        end else if (state == S_SEND) begin
            if (last_bit) begin
                state <= S_IDLE;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    piso_shift_reg #(
        .DATA_W(DATA_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift_en(state == S_SEND),
        .pi      (pi),
        .so      (so)
    );

    assign serOut   = so;
    assign serOutEn = (state == S_SEND);
    assign busy     = (state == S_SEND);
    assign done     = last_bit;

endmodule

// File: tb/tb_serial_transmitter.sv
// Self-checking bench for serial_transmitter: bit-queue reference model, vector table, loopback receiver.
module tb_serial_transmitter;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] pi = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              serOut;
    logic              serOutEn;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_transmitter #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .pi      (pi),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .serOut  (serOut),
        .serOutEn(serOutEn),
        .busy    (busy),
        .done    (done)
    );

    // Reference model: the bits the line will carry, one entry per cycle, head = current cycle.
    typedef struct packed {
        logic b;
        logic last;
    } line_bit_t;
    line_bit_t line_q[$];

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] p;
        logic              so;
        logic              en;
        logic              dn;
        logic              rdy;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic en_e;
        en_e = (line_q.size() != 0);
        chk("serOutEn", serOutEn, en_e);
        chk("busy", busy, en_e);
        chk("serOut", serOut, en_e ? line_q[0].b : 1'b0);
        chk("done", done, en_e ? line_q[0].last : 1'b0);
        chk("in_ready", in_ready, !en_e || line_q[0].last);
    endtask

    task automatic cycle(input logic r, input logic v, input logic [DATA_W-1:0] p);
        logic exp_rdy;
        logic acc;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        pi       = p;
        #1;
        exp_rdy = (line_q.size() == 0) || line_q[0].last;
        chk("in_ready_pre_edge", in_ready, exp_rdy);
        acc = !r && v && exp_rdy;
        @(posedge clk);
        #1;
        if (r) begin
            line_q.delete();
        end else begin
            if (line_q.size() != 0) void'(line_q.pop_front());
            if (acc) begin
                for (int i = DATA_W - 1; i >= 0; i--) begin
                    line_q.push_back('{b: p[i], last: (i == 0)});
                end
            end
        end
        check_outputs();
    endtask

    // Stand-in for the link receiver: shift while enabled, pulse valid after a full word.
    logic [DATA_W-1:0] rx_sh, rx_data;
    logic [2:0]        rx_cnt;
    logic              rx_valid;
    logic              lb_on = 1'b0;
    logic [DATA_W-1:0] rx_exp[$];

    always @(posedge clk) begin
        if (rst) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_cnt   <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (serOutEn) begin
                rx_sh  <= {rx_sh[DATA_W-2:0], serOut};
                rx_cnt <= rx_cnt + 3'd1;
                if (rx_cnt == 3'd7) begin
                    rx_valid <= 1'b1;
                    rx_data  <= {rx_sh[DATA_W-2:0], serOut};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (lb_on && rx_valid) begin
            if (rx_exp.size() == 0) chk("loopback_unexpected_word", rx_data, 32'hFFFF_FFFF);
            else chk("loopback_word", rx_data, rx_exp.pop_front());
        end
    end

    initial begin
        logic              r;
        logic              v;
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] lb_words[3];

        // Single word 8'hA5: expected outputs after each edge.
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'hFF);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_serOutEn", serOutEn, 1'b0);

        // Idle line after reset.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 8'($urandom));

        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, tbl[i].v, tbl[i].p);
            chk("tbl_serOut", serOut, tbl[i].so);
            chk("tbl_serOutEn", serOutEn, tbl[i].en);
            chk("tbl_done", done, tbl[i].dn);
            chk("tbl_in_ready", in_ready, tbl[i].rdy);
        end

        // Back-to-back FF then 00 with in_valid held.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'hFF);
        cycle(1'b0, 1'b1, 8'h00);
        chk("b2b_no_gap_en", serOutEn, 1'b1);
        chk("b2b_second_word_msb", serOut, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 8'h00);

        // Backpressure: 3C accepted, then C3 held until the last-bit cycle.
        cycle(1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'hC3);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 8'h00);

        // Reset after three bits of 8'h81, then a fresh word.
        cycle(1'b0, 1'b1, 8'h81);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h42);
        chk("midrst_serOut", serOut, 1'b0);
        chk("midrst_serOutEn", serOutEn, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        cycle(1'b0, 1'b1, 8'h66);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 8'h00);

        // Loopback through the receiver.
        cycle(1'b1, 1'b0, 8'h00);
        lb_words[0] = 8'h5A;
        lb_words[1] = 8'h96;
        lb_words[2] = 8'h01;
        lb_on = 1'b1;
        for (int w = 0; w < 3; w++) begin
            rx_exp.push_back(lb_words[w]);
            cycle(1'b0, 1'b1, lb_words[w]);
            for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 8'h00);
        end
        chk("loopback_all_received", rx_exp.size(), 0);
        lb_on = 1'b0;

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = 8'($urandom);
            cycle(r, v, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
